// File: rtl/open_riscv_soc.sv
// open_riscv_soc: two-stage RV32I core, synchronous instruction ROM and optional data RAM.
// Build option: define DATA_RAM_EN to add the data RAM (ram_inst) and load/store support.

// Generic one-write/one-read word memory with a registered read port.
// Latency: read data valid one clock after the address.
// Backpressure: none, accepts one read and one write every clock.
module dual_ram_template #(
  parameter int DW    = 32,
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_dat,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_dat
);
  logic [DW-1:0] memory [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (wr_en) memory[wr_addr] <= wr_dat;
    rd_dat <= memory[rd_addr];
  end
endmodule

// ROM storage wrapper: write port tied off, contents preloaded from outside.
// Latency: one clock.
// Backpressure: none.
module open_riscv_rom_mem #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  output logic [31:0]   rd_dat
);
  dual_ram_template #(.DW(32), .DEPTH(DEPTH)) dual_ram_template_inst (
    .clk     (clk),
    .wr_en   (1'b0),
    .wr_addr ('0),
    .wr_dat  ('0),
    .rd_addr (addr),
    .rd_dat  (rd_dat)
  );
endmodule

// Instruction ROM, word addressed.
// Latency: one clock.
// Backpressure: none.
module open_riscv_rom #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  output logic [31:0]   rd_dat
);
  open_riscv_rom_mem #(.DEPTH(DEPTH)) rom_mem (
    .clk    (clk),
    .addr   (addr),
    .rd_dat (rd_dat)
  );
endmodule

`ifdef DATA_RAM_EN
// Data RAM with byte enables.
// Latency: combinational read, write on the rising edge.
// Backpressure: none.
module open_riscv_ram #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          wr_en,
  input  logic [3:0]    be,
  input  logic [31:0]   wr_dat,
  output logic [31:0]   rd_dat
);
  logic [31:0] memory [0:DEPTH-1];

  assign rd_dat = memory[addr];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (wr_en && be[b]) memory[addr][8*b +: 8] <= wr_dat[8*b +: 8];
  end
endmodule
`endif

// 32 x 32 register file, x0 hardwired to zero.
// Latency: combinational reads, write visible after the rising edge.
// Backpressure: none.
module open_riscv_regs (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_dat,
  output logic [31:0] rs2_dat,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_dat
);
  logic [31:0] regs [0:31];

  assign rs1_dat = (rs1_addr == 5'd0) ? 32'd0 : regs[rs1_addr];
  assign rs2_dat = (rs2_addr == 5'd0) ? 32'd0 : regs[rs2_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_en && wr_addr != 5'd0) begin
      regs[wr_addr] <= wr_dat;
    end
  end
endmodule

// Two-stage RV32I core: fetch (registered ROM read) then decode/execute/write-back.
// Latency: one instruction per clock, one bubble after a taken branch or jump.
// Backpressure: none, the pipeline never stalls.
module open_risc_v #(
  parameter int          ROM_AW   = 12,
`ifdef DATA_RAM_EN
  parameter int          RAM_AW   = 12,
`endif
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_dat
`ifdef DATA_RAM_EN
  ,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_wr_en,
  output logic [3:0]        ram_be,
  output logic [31:0]       ram_wr_dat,
  input  logic [31:0]       ram_rd_dat
`endif
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [31:0] pc, pc_q, inst;
  logic        fetch_vld;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_b, imm_u, imm_j;
  logic [31:0] rs1_dat, rs2_dat;
  logic        br_cond, taken, wb_en;
  logic [31:0] wb_dat, target;

  assign inst   = rom_dat;
  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'b0};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  open_riscv_regs regs_inst (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (inst[19:15]),
    .rs2_addr (inst[24:20]),
    .rs1_dat  (rs1_dat),
    .rs2_dat  (rs2_dat),
    .wr_en    (wb_en),
    .wr_addr  (inst[11:7]),
    .wr_dat   (wb_dat)
  );

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] op, input logic alt);
    case (op)
      3'b000:  alu = alt ? a - b : a + b;
      3'b001:  alu = a << b[4:0];
      3'b010:  alu = {31'b0, $signed(a) < $signed(b)};
      3'b011:  alu = {31'b0, a < b};
      3'b100:  alu = a ^ b;
      // kept out of a ?: so the arithmetic shift stays in a signed context
      3'b101:  if (alt) alu = $signed(a) >>> b[4:0]; else alu = a >> b[4:0];
      3'b110:  alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  always_comb begin
    case (f3)
      3'b000:  br_cond = rs1_dat == rs2_dat;
      3'b001:  br_cond = rs1_dat != rs2_dat;
      3'b100:  br_cond = $signed(rs1_dat) <  $signed(rs2_dat);
      3'b101:  br_cond = $signed(rs1_dat) >= $signed(rs2_dat);
      3'b110:  br_cond = rs1_dat <  rs2_dat;
      3'b111:  br_cond = rs1_dat >= rs2_dat;
      default: br_cond = 1'b0;
    endcase
  end

`ifdef DATA_RAM_EN
  logic [31:0] imm_s, ls_addr, ld_dat;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        unused_addr_bits;

  assign imm_s            = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign ls_addr          = rs1_dat + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign ram_addr         = ls_addr[RAM_AW+1:2];
  assign unused_addr_bits = ^ls_addr[31:RAM_AW+2];
  assign ld_byte          = 8'(ram_rd_dat >> {ls_addr[1:0], 3'b000});
  assign ld_half          = ls_addr[1] ? ram_rd_dat[31:16] : ram_rd_dat[15:0];

  always_comb begin
    case (f3)
      3'b000:  ld_dat = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_dat = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_dat = {24'b0, ld_byte};
      3'b101:  ld_dat = {16'b0, ld_half};
      default: ld_dat = ram_rd_dat;
    endcase
    case (f3[1:0])
      2'b00: begin
        ram_be     = 4'b0001 << ls_addr[1:0];
        ram_wr_dat = {4{rs2_dat[7:0]}};
      end
      2'b01: begin
        ram_be     = ls_addr[1] ? 4'b1100 : 4'b0011;
        ram_wr_dat = {2{rs2_dat[15:0]}};
      end
      default: begin
        ram_be     = 4'b1111;
        ram_wr_dat = rs2_dat;
      end
    endcase
  end

  assign ram_wr_en = fetch_vld && (opcode == OP_STORE);
`endif

  always_comb begin
    wb_en  = 1'b0;
    wb_dat = '0;
    taken  = 1'b0;
    target = '0;
    if (fetch_vld) begin
      case (opcode)
        OP_LUI:   begin wb_en = 1'b1; wb_dat = imm_u; end
        OP_AUIPC: begin wb_en = 1'b1; wb_dat = pc_q + imm_u; end
        OP_JAL: begin
          wb_en  = 1'b1;
          wb_dat = pc_q + 32'd4;
          taken  = 1'b1;
          target = pc_q + imm_j;
        end
        OP_JALR: begin
          wb_en  = 1'b1;
          wb_dat = pc_q + 32'd4;
          taken  = 1'b1;
          target = (rs1_dat + imm_i) & ~32'd1;
        end
        OP_BRANCH: begin
          taken  = br_cond;
          target = pc_q + imm_b;
        end
        OP_IMM: begin
          wb_en  = 1'b1;
          wb_dat = alu(rs1_dat, imm_i, f3, (f3 == 3'b101) && inst[30]);
        end
        OP_REG: begin
          wb_en  = 1'b1;
          wb_dat = alu(rs1_dat, rs2_dat, f3, inst[30]);
        end
        OP_LOAD: begin
          wb_en  = 1'b1;
`ifdef DATA_RAM_EN
          wb_dat = ld_dat;
`else
          wb_dat = '0;
`endif
        end
        default: ;
      endcase
    end
  end

  // A taken branch squashes the word being fetched in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      pc_q      <= RESET_PC;
      fetch_vld <= 1'b0;
    end else begin
      pc_q      <= pc;
      fetch_vld <= !taken;
      pc        <= taken ? target : pc + 32'd4;
    end
  end

  assign rom_addr = pc[ROM_AW+1:2];
endmodule

// SoC top: core, instruction ROM and (with DATA_RAM_EN) data RAM.
// Latency: one instruction per clock after the first fetch.
// Backpressure: none.
module open_riscv_soc #(
  parameter int          ROM_DEPTH = 4096,
  parameter int          RAM_DEPTH = 4096,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input logic clk,
  input logic rst
);
  localparam int ROM_AW = $clog2(ROM_DEPTH);

  logic [ROM_AW-1:0] rom_addr;
  logic [31:0]       rom_dat;

  open_riscv_rom #(.DEPTH(ROM_DEPTH)) rom_inst (
    .clk    (clk),
    .addr   (rom_addr),
    .rd_dat (rom_dat)
  );

`ifdef DATA_RAM_EN
  localparam int RAM_AW = $clog2(RAM_DEPTH);

  logic [RAM_AW-1:0] ram_addr;
  logic              ram_wr_en;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wr_dat, ram_rd_dat;

  open_riscv_ram #(.DEPTH(RAM_DEPTH)) ram_inst (
    .clk    (clk),
    .addr   (ram_addr),
    .wr_en  (ram_wr_en),
    .be     (ram_be),
    .wr_dat (ram_wr_dat),
    .rd_dat (ram_rd_dat)
  );

  open_risc_v #(.ROM_AW(ROM_AW), .RAM_AW(RAM_AW), .RESET_PC(RESET_PC)) open_risc_v_inst (
    .clk        (clk),
    .rst        (rst),
    .rom_addr   (rom_addr),
    .rom_dat    (rom_dat),
    .ram_addr   (ram_addr),
    .ram_wr_en  (ram_wr_en),
    .ram_be     (ram_be),
    .ram_wr_dat (ram_wr_dat),
    .ram_rd_dat (ram_rd_dat)
  );
`else
  localparam int unused_ram_depth = RAM_DEPTH;

  open_risc_v #(.ROM_AW(ROM_AW), .RESET_PC(RESET_PC)) open_risc_v_inst (
    .clk      (clk),
    .rst      (rst),
    .rom_addr (rom_addr),
    .rom_dat  (rom_dat)
  );
`endif
endmodule

// File: tb/tb_open_riscv_soc.sv
// Bench for open_riscv_soc: loads small programs into the ROM and scoreboards register results.
module tb_open_riscv_soc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int pw = 0;
  int          exp_reg[$];
  logic [31:0] exp_val[$];

  open_riscv_soc dut (.clk(clk), .rst(rst));

  always #5 clk = ~clk;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic [31:0] f_i(input logic [6:0] op, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] f_r(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] f_s(input logic [2:0] f3, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] f_b(input logic [2:0] f3, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] f_u(input logic [6:0] op, input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] f_j(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction
  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return f_i(7'h13, 3'd0, rd, rs1, imm);
  endfunction

  function automatic logic [31:0] rv(input int r);
    return dut.open_risc_v_inst.regs_inst.regs[r];
  endfunction

  task automatic put(input logic [31:0] w);
    dut.rom_inst.rom_mem.dual_ram_template_inst.memory[pw] = w;
    pw++;
  endtask

  task automatic new_prog();
    rst = 1'b1;
    for (int i = 0; i < 4096; i++) dut.rom_inst.rom_mem.dual_ram_template_inst.memory[i] = NOP;
    pw = 0;
    exp_reg.delete();
    exp_val.delete();
  endtask

  task automatic expect_reg(input int r, input logic [31:0] v);
    exp_reg.push_back(r);
    exp_val.push_back(v);
  endtask

  task automatic go();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    new_prog();
    put(addi(1, 0, 12'd5)); put(addi(2, 0, 12'd6)); put(addi(3, 0, 12'd7)); put(f_j(0, 21'd0));
    expect_reg(1, 32'd5); expect_reg(2, 32'd6); expect_reg(3, 32'd7);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rv(1) !== 32'd0) begin errors++; $display("FAIL reset_hold x1: got %h expected %h", rv(1), 32'd0); end
    go();
    @(posedge clk); #1;
    checks++;
    if (rv(1) !== 32'd0) begin errors++; $display("FAIL reset_first_edge x1: got %h expected %h", rv(1), 32'd0); end
    @(posedge clk); #1;
    checks++;
    if (rv(1) !== 32'd5) begin errors++; $display("FAIL reset_first_exec x1: got %h expected %h", rv(1), 32'd5); end
    // reset while ADDI x2 is executing
    #2 rst = 1'b1;
    #1;
    checks++;
    if (rv(1) !== 32'd0) begin errors++; $display("FAIL reset_async_clear x1: got %h expected %h", rv(1), 32'd0); end
    @(posedge clk); #1;
    checks++;
    if (rv(2) !== 32'd0) begin errors++; $display("FAIL reset_inflight x2: got %h expected %h", rv(2), 32'd0); end
    go();
    repeat (8) @(posedge clk);
    #1;
    while (exp_reg.size() > 0) begin
      int r;
      logic [31:0] v;
      r = exp_reg.pop_front();
      v = exp_val.pop_front();
      checks++;
      if (rv(r) !== v) begin errors++; $display("FAIL reset_restart x%0d: got %h expected %h", r, rv(r), v); end
    end
  endtask

  task automatic test_alu();
    new_prog();
    put(addi(1, 0, 12'hFFF));                  expect_reg(1, 32'hFFFF_FFFF);
    put(addi(2, 1, 12'd1));                    expect_reg(2, 32'h0);
    put(addi(0, 0, 12'd7));                    expect_reg(0, 32'h0);
    put(f_u(7'h37, 3, 20'h80000));             expect_reg(3, 32'h8000_0000);
    put(f_i(7'h13, 3'd5, 4, 3, 12'h404));      expect_reg(4, 32'hF800_0000);
    put(f_i(7'h13, 3'd5, 5, 3, 12'h004));      expect_reg(5, 32'h0800_0000);
    put(f_r(7'h00, 3'd2, 6, 3, 0));            expect_reg(6, 32'd1);
    put(f_r(7'h00, 3'd3, 7, 3, 0));            expect_reg(7, 32'd0);
    put(f_r(7'h20, 3'd0, 8, 0, 1));            expect_reg(8, 32'd1);
    put(f_i(7'h13, 3'd1, 9, 1, 12'h01F));      expect_reg(9, 32'h8000_0000);
    put(f_i(7'h13, 3'd3, 10, 0, 12'hFFF));     expect_reg(10, 32'd1);
    put(f_r(7'h00, 3'd4, 11, 1, 3));           expect_reg(11, 32'h7FFF_FFFF);
    expect_reg(12, 32'h1000 + 32'(pw * 4));
    put(f_u(7'h17, 12, 20'h00001));
    put(32'h0000_0073);
    put({12'h300, 5'd1, 3'b001, 5'd17, 7'h73}); expect_reg(17, 32'd0);
    put(f_i(7'h13, 3'd7, 13, 1, 12'h0F0));     expect_reg(13, 32'h0000_00F0);
    put(addi(15, 0, 12'd33));                  expect_reg(15, 32'd33);
    put(f_r(7'h00, 3'd1, 14, 15, 15));         expect_reg(14, 32'd66);
    put(f_i(7'h13, 3'd6, 16, 0, 12'h800));     expect_reg(16, 32'hFFFF_F800);
    put(f_r(7'h20, 3'd5, 18, 3, 15));          expect_reg(18, 32'hC000_0000);
    put(f_j(0, 21'd0));
    go();
    repeat (30) @(posedge clk);
    #1;
    while (exp_reg.size() > 0) begin
      int r;
      logic [31:0] v;
      r = exp_reg.pop_front();
      v = exp_val.pop_front();
      checks++;
      if (rv(r) !== v) begin errors++; $display("FAIL alu x%0d: got %h expected %h", r, rv(r), v); end
    end
  endtask

  task automatic test_back_to_back();
    new_prog();
    put(addi(1, 0, 12'd1));
    for (int i = 0; i < 5; i++) put(f_r(7'h00, 3'd0, 1, 1, 1));
    put(f_j(0, 21'd0));
    expect_reg(1, 32'd32);
    go();
    repeat (7) @(posedge clk);
    #1;
    while (exp_reg.size() > 0) begin
      int r;
      logic [31:0] v;
      r = exp_reg.pop_front();
      v = exp_val.pop_front();
      checks++;
      if (rv(r) !== v) begin errors++; $display("FAIL back_to_back x%0d: got %h expected %h", r, rv(r), v); end
    end
  endtask

  task automatic test_branch_flush();
    new_prog();
    put(f_b(3'd0, 0, 0, 13'd8));   put(addi(5, 0, 12'd9));  put(addi(6, 0, 12'd1));
    put(f_b(3'd1, 0, 0, 13'd8));   put(addi(7, 0, 12'd3));  put(addi(1, 0, 12'hFFF));
    put(f_b(3'd6, 0, 1, 13'd8));   put(addi(8, 0, 12'd1));
    put(f_b(3'd5, 1, 0, 13'd8));   put(addi(9, 0, 12'd2));
    put(f_b(3'd4, 1, 0, 13'd8));   put(addi(10, 0, 12'd1));
    put(f_b(3'd7, 1, 0, 13'd8));   put(addi(20, 0, 12'd1));
    put(f_j(0, 21'd0));
    expect_reg(5, 32'd0); expect_reg(6, 32'd1); expect_reg(7, 32'd3); expect_reg(8, 32'd0);
    expect_reg(9, 32'd2); expect_reg(10, 32'd0); expect_reg(20, 32'd0);
    go();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rv(6) !== 32'd0) begin errors++; $display("FAIL flush_bubble x6 early: got %h expected %h", rv(6), 32'd0); end
    @(posedge clk); #1;
    checks++;
    if (rv(6) !== 32'd1) begin errors++; $display("FAIL flush_bubble x6 on time: got %h expected %h", rv(6), 32'd1); end
    repeat (25) @(posedge clk);
    #1;
    while (exp_reg.size() > 0) begin
      int r;
      logic [31:0] v;
      r = exp_reg.pop_front();
      v = exp_val.pop_front();
      checks++;
      if (rv(r) !== v) begin errors++; $display("FAIL branch x%0d: got %h expected %h", r, rv(r), v); end
    end
  endtask

  task automatic test_jal_jalr();
    new_prog();
    repeat (4) put(NOP);
    put(f_j(1, 21'd12));
    put(addi(11, 11, 12'd1));
    put(f_j(0, 21'd0));
    put(addi(12, 0, 12'd7));
    put(f_i(7'h67, 3'd0, 0, 1, 12'd1));
    expect_reg(1, 32'h14); expect_reg(11, 32'd1); expect_reg(12, 32'd7);
    go();
    repeat (7) @(posedge clk);
    #1;
    checks++;
    if (rv(12) !== 32'd0) begin errors++; $display("FAIL jal_target x12 early: got %h expected %h", rv(12), 32'd0); end
    @(posedge clk); #1;
    checks++;
    if (rv(12) !== 32'd7) begin errors++; $display("FAIL jal_target x12 at 0x1c: got %h expected %h", rv(12), 32'd7); end
    repeat (15) @(posedge clk);
    #1;
    while (exp_reg.size() > 0) begin
      int r;
      logic [31:0] v;
      r = exp_reg.pop_front();
      v = exp_val.pop_front();
      checks++;
      if (rv(r) !== v) begin errors++; $display("FAIL jal_jalr x%0d: got %h expected %h", r, rv(r), v); end
    end
  endtask

  task automatic test_ram();
    new_prog();
`ifdef DATA_RAM_EN
    put(f_u(7'h37, 2, 20'h80818));
    put(addi(2, 2, 12'h283));
    put(f_s(3'd2, 0, 2, 12'd4));
    put(f_i(7'h03, 3'd0, 3, 0, 12'd4));  expect_reg(3, 32'hFFFF_FF83);
    put(f_i(7'h03, 3'd5, 4, 0, 12'd4));  expect_reg(4, 32'h0000_8283);
    put(f_i(7'h03, 3'd2, 5, 0, 12'd4));  expect_reg(5, 32'h8081_8283);
    put(f_i(7'h03, 3'd1, 6, 0, 12'd6));  expect_reg(6, 32'hFFFF_8081);
    put(f_i(7'h03, 3'd4, 7, 0, 12'd5));  expect_reg(7, 32'h0000_0082);
    put(f_s(3'd2, 0, 0, 12'd8));
    put(f_s(3'd0, 0, 2, 12'd9));
    put(f_i(7'h03, 3'd2, 8, 0, 12'd8));  expect_reg(8, 32'h0000_8300);
    put(f_i(7'h03, 3'd2, 9, 0, 12'd7));  expect_reg(9, 32'h8081_8283);
`else
    put(addi(5, 0, 12'd9));
    put(f_i(7'h03, 3'd2, 5, 0, 12'd4));  expect_reg(5, 32'd0);
    put(f_s(3'd2, 0, 5, 12'd0));
    put(addi(6, 0, 12'd1));              expect_reg(6, 32'd1);
`endif
    put(f_j(0, 21'd0));
    go();
    repeat (20) @(posedge clk);
    #1;
    while (exp_reg.size() > 0) begin
      int r;
      logic [31:0] v;
      r = exp_reg.pop_front();
      v = exp_val.pop_front();
      checks++;
      if (rv(r) !== v) begin errors++; $display("FAIL ram x%0d: got %h expected %h", r, rv(r), v); end
    end
  endtask

  task automatic test_compliance();
    new_prog();
    put(addi(3, 0, 12'd2));
    put(f_u(7'h37, 1, 20'hFF010)); put(addi(1, 1, 12'hF00));
    put(f_u(7'h37, 2, 20'h0F0F1)); put(addi(2, 2, 12'hFF0));
    put(f_r(7'h00, 3'd4, 14, 1, 2));
    put(f_u(7'h37, 7, 20'hF00FF)); put(addi(7, 7, 12'h0F0));
    put(f_b(3'd1, 14, 7, 13'(128 - pw * 4)));
    put(addi(3, 0, 12'd3));
    put(f_i(7'h13, 3'd4, 14, 1, 12'hFFF));
    put(f_u(7'h37, 7, 20'h00FF0)); put(addi(7, 7, 12'h0FF));
    put(f_b(3'd1, 14, 7, 13'(128 - pw * 4)));
    put(addi(3, 0, 12'd4));
    put(f_r(7'h00, 3'd4, 1, 1, 1));
    put(f_b(3'd1, 1, 0, 13'(128 - pw * 4)));
    put(addi(27, 0, 12'd1)); put(addi(26, 0, 12'd1)); put(f_j(0, 21'd0));
    pw = 32;
    put(addi(26, 0, 12'd1)); put(f_j(0, 21'd0));
    expect_reg(26, 32'd1); expect_reg(27, 32'd1); expect_reg(3, 32'd4);
    expect_reg(14, 32'h00FF_00FF); expect_reg(1, 32'd0);
    go();
    repeat (40) @(posedge clk);
    #1;
    while (exp_reg.size() > 0) begin
      int r;
      logic [31:0] v;
      r = exp_reg.pop_front();
      v = exp_val.pop_front();
      checks++;
      if (rv(r) !== v) begin errors++; $display("FAIL compliance x%0d: got %h expected %h", r, rv(r), v); end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_branch_flush();
    test_jal_jalr();
    test_ram();
    test_compliance();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/open_riscv_soc.md
# open_riscv_soc

Minimal RV32I system-on-chip top: a compact two-stage RISC-V integer core, a word-addressed instruction ROM and an optional data RAM, driven only by clock and reset. It is the top-level simulation target for running compliance-style programs preloaded into the ROM. Pass/fail is read from core registers x26 (done flag) and x27 (pass flag).

## Interface
- ROM_DEPTH, 4096: instruction ROM depth in 32-bit words (power of two).
- RAM_DEPTH, 4096: data RAM depth in 32-bit words (used only with DATA_RAM_EN).
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.

## Operation
- Fixed hierarchy:
  - core instance `open_risc_v_inst`;
  - register file `open_risc_v_inst.regs_inst.regs[0:31]`, 32-bit each;
  - ROM storage `rom_inst.rom_mem.dual_ram_template_inst.memory[0:ROM_DEPTH-1]`, 32-bit words.
- ROM contents are loaded externally by a hex memory-load before reset release. The SoC never writes the ROM.
- ROM is addressed by pc[log2(ROM_DEPTH)+1:2]. Upper PC bits are ignored, so addresses wrap.
- Supported instructions:
  - LUI, AUIPC, JAL, JALR (target bit 0 cleared);
  - BEQ/BNE/BLT/BGE/BLTU/BGEU;
  - ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI;
  - ADD/SUB/SLL/SLT/SLTU/XOR/OR/AND/SRL/SRA.
- Arithmetic is 32-bit modulo 2^32 and never traps. Shift amount is rs2[4:0] or shamt[4:0]. Signed compares use two's complement.
- FENCE, ECALL, EBREAK, CSR instructions and undefined opcodes execute as NOP: no register write, PC+4.
- Register file behaviour:
  - x0 reads 0; writes to x0 are discarded;
  - two combinational read ports, one write port written at the end of the execute cycle.

## Timing
- Reset (asynchronous, while rst=1):
  - PC = RESET_PC;
  - fetch-valid = 0;
  - all 32 registers = 0.
- Stage 1 (fetch): synchronous ROM read of PC; PC advances by 4 each cycle.
- Stage 2 (execute): decode, ALU, branch resolve and register write-back, all in one cycle.
- First instruction after reset release:
  - reset deasserts before edge N;
  - edge N registers the ROM read of RESET_PC;
  - the instruction executes in cycle N+1 and its write-back is visible after edge N+1.
- Steady-state throughput is 1 instruction/clock.
- Taken branch or jump:
  - PC loads the target at the end of the execute cycle;
  - the one already-fetched instruction is squashed (no write-back);
  - penalty is 1 bubble cycle.
- Back-to-back dependent instructions need no stall: the register write at edge k is visible to the read in cycle k+1.
- Reset asserted mid-program: all state clears immediately. The in-flight instruction does not write back. Execution restarts at RESET_PC after release.

## Configuration
- DATA_RAM_EN defined:
  - adds a RAM_DEPTH-word data RAM (`ram_inst`) at byte address 0, with address wrap;
  - implements LB/LH/LW/LBU/LHU and SB/SH/SW;
  - stores are byte-enabled and write at the end of the execute cycle;
  - loads read combinationally in execute and are sign- or zero-extended;
  - misaligned accesses use the address with the low bits dropped to the access width.
- DATA_RAM_EN undefined:
  - loads write 0 to rd;
  - stores are ignored;
  - no RAM is instantiated.

## Test plan
- Compliance run: preload the XOR test program image and run to completion. Required: x26=1, x27=1, and x3 holds the final test number.
- Reset sequencing: ROM[0]=ADDI x1,x0,5. Check x1=0 while rst=1 and x1=5 one clock after the first execute edge.
- ALU wrap and x0: ADDI x1,x0,-1; ADDI x2,x1,1; ADDI x0,x0,7. Required: x1=32'hFFFF_FFFF, x2=0, x0=0.
- Branch flush: BEQ x0,x0,+8 followed by ADDI x5,x0,9. Required: x5 stays 0 and exactly 1 bubble cycle occurs.
- JAL/JALR: JAL x1,+12 at PC 0x10. Required: x1=0x14 and next PC 0x1C. Then JALR x0,x1,1 jumps to 0x14 (bit 0 cleared).
- DATA_RAM_EN: SW x2=0x8081_8283 to address 4, then LB gives 32'hFFFF_FF83 and LHU gives 0x8283. Without DATA_RAM_EN, LW writes 0 to rd.
